// File: rtl/tug_field.sv
// tug_field: tug-of-war playfield with a single lit LED, round-win detection and per-player saturating scores.
// Latency: one cycle; a press sampled at a rising edge updates lights, winner and scores at that same edge.
// Backpressure: none; presses arriving while a round is won are dropped, and restart holds play off while high.
module tug_field #(
    parameter int NUM_LIGHTS = 9,
    parameter int SCORE_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
    input  logic                  restart,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [1:0]            winner,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r
);

    localparam int                  PW        = $clog2(NUM_LIGHTS);
    localparam logic [PW-1:0]       POS_C     = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PW-1:0]       POS_MAX   = PW'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0]  SCORE_MAX = '1;

    // Encoding matches the winner output so a won state reads directly as the flag pair.
    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_WIN_L = 2'b10,
        ST_WIN_R = 2'b01
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 l_prev_q, l_prev_d;
    logic                 r_prev_q, r_prev_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d;
    logic [SCORE_W-1:0]   score_r_q, score_r_d;

    logic                 l_press;
    logic                 r_press;

    // Rising-edge press detect; prev samples reset high so a button held through reset is not a press.
    assign l_press = L & ~l_prev_q;
    assign r_press = R & ~r_prev_q;

    // State, position, edge-detect history and score registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_PLAY;
            pos_q     <= POS_C;
            l_prev_q  <= 1'b1;
            r_prev_q  <= 1'b1;
            score_l_q <= '0;
            score_r_q <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            l_prev_q  <= l_prev_d;
            r_prev_q  <= r_prev_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    // Next-state: restart dominates, simultaneous presses cancel, stepping off either end wins the round.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        // Edge-detect history follows the buttons in every state, so presses made during a win are consumed.
        l_prev_d  = L;
        r_prev_d  = R;

        case (state_q)
            ST_PLAY: begin
                if (restart) begin
                    pos_d = POS_C;
                end else if (l_press && !r_press) begin
                    if (pos_q == POS_MAX) begin
                        state_d = ST_WIN_L;
                        if (score_l_q != SCORE_MAX) begin
                            score_l_d = score_l_q + 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (r_press && !l_press) begin
                    if (pos_q == '0) begin
                        state_d = ST_WIN_R;
                        if (score_r_q != SCORE_MAX) begin
                            score_r_d = score_r_q + 1'b1;
                        end
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            ST_WIN_L, ST_WIN_R: begin
                if (restart) begin
                    state_d = ST_PLAY;
                    pos_d   = POS_C;
                end
            end
            default: begin
                state_d = ST_PLAY;
                pos_d   = POS_C;
            end
        endcase
    end

    // Output decode from registered state only; no input reaches an output combinationally.
    always_comb begin
        lights = '0;
        winner = 2'b00;
        case (state_q)
            ST_PLAY:  lights = NUM_LIGHTS'(1) << pos_q;
            ST_WIN_L: winner = 2'b10;
            ST_WIN_R: winner = 2'b01;
            default:  winner = 2'b00;
        endcase
    end

    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: tb/tb_tug_field.sv
// Testbench for tug_field: directed vector table, multi-cycle corner sequences and randomized play
// checked against a behavioural game model.
module tb_tug_field;

    localparam int N    = 9;
    localparam int SW   = 2;
    localparam int C    = (N - 1) / 2;
    localparam int SMAX = (1 << SW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           L;
    logic           R;
    logic           restart;
    logic [N-1:0]   lights;
    logic [1:0]     winner;
    logic [SW-1:0]  score_l;
    logic [SW-1:0]  score_r;

    tug_field #(.NUM_LIGHTS(N), .SCORE_W(SW)) dut (
        .clk     (clk),
        .reset   (reset),
        .L       (L),
        .R       (R),
        .restart (restart),
        .lights  (lights),
        .winner  (winner),
        .score_l (score_l),
        .score_r (score_r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural game model: position as an integer, who-won as 0 none / 1 left / 2 right.
    int m_pos;
    int m_win;
    int m_sl;
    int m_sr;
    bit m_lp;
    bit m_rp;

    function automatic void model_reset();
        m_pos = C;
        m_win = 0;
        m_sl  = 0;
        m_sr  = 0;
        m_lp  = 1'b1;
        m_rp  = 1'b1;
    endfunction

    function automatic void model_step();
        bit pl;
        bit pr;
        pl   = L && !m_lp;
        pr   = R && !m_rp;
        m_lp = L;
        m_rp = R;
        if (m_win != 0) begin
            if (restart) begin
                m_win = 0;
                m_pos = C;
            end
        end else if (restart) begin
            m_pos = C;
        end else if (pl && !pr) begin
            if (m_pos + 1 > N - 1) begin
                m_win = 1;
                m_sl  = (m_sl + 1 > SMAX) ? SMAX : m_sl + 1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else if (pr && !pl) begin
            if (m_pos - 1 < 0) begin
                m_win = 2;
                m_sr  = (m_sr + 1 > SMAX) ? SMAX : m_sr + 1;
            end else begin
                m_pos = m_pos - 1;
            end
        end
    endfunction

    function automatic logic [N-1:0] m_lights();
        logic [N-1:0] v;
        v = '0;
        if (m_win == 0) v[m_pos] = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] m_winner();
        if (m_win == 1) return 2'b10;
        if (m_win == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_exp(input string tag, input logic [N-1:0] lt, input logic [1:0] w,
                             input int sl, input int sr);
        cmp({tag, ".lights"},  32'(lights),  32'(lt));
        cmp({tag, ".winner"},  32'(winner),  32'(w));
        cmp({tag, ".score_l"}, 32'(score_l), sl);
        cmp({tag, ".score_r"}, 32'(score_r), sr);
    endtask

    task automatic check_model(input string tag);
        check_exp(tag, m_lights(), m_winner(), m_sl, m_sr);
    endtask

    task automatic set_in(input logic l, input logic r, input logic rs);
        L       = l;
        R       = r;
        restart = rs;
    endtask

    // One active edge; the model advances on the same sampled inputs, outputs are read 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Called 1ns after an edge: reset rises and falls while the clock is between edges.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_exp(tag, N'(1) << C, 2'b00, 0, 0);
        model_reset();
        #3 reset = 1'b0;
    endtask

    typedef struct {
        logic         l;
        logic         r;
        logic         rs;
        logic [N-1:0] lt;
        logic [1:0]   w;
        int           sl;
        int           sr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic l, input logic r, input logic rs,
                                input logic [N-1:0] lt, input logic [1:0] w, input int sl, input int sr);
        vec_t v;
        v.l = l; v.r = r; v.rs = rs; v.lt = lt; v.w = w; v.sl = sl; v.sr = sr;
        tbl.push_back(v);
    endfunction

    initial begin
        // Directed vectors, applied from a fresh reset with all inputs low for one idle cycle.
        add(1, 0, 0, 9'h020, 2'b00, 0, 0);
        add(0, 0, 0, 9'h020, 2'b00, 0, 0);
        add(1, 0, 0, 9'h040, 2'b00, 0, 0);
        add(0, 0, 0, 9'h040, 2'b00, 0, 0);
        add(1, 0, 0, 9'h080, 2'b00, 0, 0);
        add(0, 0, 0, 9'h080, 2'b00, 0, 0);
        add(1, 0, 0, 9'h100, 2'b00, 0, 0);
        add(0, 0, 0, 9'h100, 2'b00, 0, 0);
        add(1, 0, 0, 9'h000, 2'b10, 1, 0);   // fifth L press wins for left
        add(0, 0, 0, 9'h000, 2'b10, 1, 0);
        add(0, 1, 0, 9'h000, 2'b10, 1, 0);   // presses ignored while won
        add(0, 0, 0, 9'h000, 2'b10, 1, 0);
        add(1, 0, 0, 9'h000, 2'b10, 1, 0);
        add(0, 0, 0, 9'h000, 2'b10, 1, 0);
        add(0, 0, 1, 9'h010, 2'b00, 1, 0);   // restart keeps score
        add(0, 0, 0, 9'h010, 2'b00, 1, 0);
        add(1, 1, 0, 9'h010, 2'b00, 1, 0);   // simultaneous presses cancel
        add(1, 0, 0, 9'h010, 2'b00, 1, 0);   // L still held: no new press
        add(0, 0, 0, 9'h010, 2'b00, 1, 0);
        add(1, 0, 0, 9'h020, 2'b00, 1, 0);   // L goes high and stays for 10 cycles
        for (int i = 0; i < 9; i++) add(1, 0, 0, 9'h020, 2'b00, 1, 0);
        add(0, 0, 0, 9'h020, 2'b00, 1, 0);
        add(0, 1, 1, 9'h010, 2'b00, 1, 0);   // restart beats a concurrent R press
        add(0, 0, 0, 9'h010, 2'b00, 1, 0);
        add(0, 1, 0, 9'h008, 2'b00, 1, 0);
        add(0, 0, 0, 9'h008, 2'b00, 1, 0);
        add(0, 0, 1, 9'h010, 2'b00, 1, 0);
        add(1, 0, 1, 9'h010, 2'b00, 1, 0);   // restart held off play
        add(0, 0, 1, 9'h010, 2'b00, 1, 0);
        add(1, 0, 1, 9'h010, 2'b00, 1, 0);
        add(0, 0, 0, 9'h010, 2'b00, 1, 0);

        // Reset asserted with L already held; L must be released before it counts.
        set_in(1, 0, 0);
        reset = 1'b1;
        model_reset();
        #12 reset = 1'b0;
        check_exp("reset", 9'h010, 2'b00, 0, 0);
        repeat (3) begin
            tick();
            check_exp("hold_L_thru_reset", 9'h010, 2'b00, 0, 0);
        end
        set_in(0, 0, 0);
        tick();
        check_exp("L_released", 9'h010, 2'b00, 0, 0);
        set_in(1, 0, 0);
        tick();
        check_exp("L_repressed", 9'h020, 2'b00, 0, 0);
        set_in(0, 0, 0);
        async_reset("reset_after_move");
        tick();
        check_exp("idle", 9'h010, 2'b00, 0, 0);

        foreach (tbl[i]) begin
            set_in(tbl[i].l, tbl[i].r, tbl[i].rs);
            tick();
            check_exp($sformatf("vec%0d", i), tbl[i].lt, tbl[i].w, tbl[i].sl, tbl[i].sr);
        end

        // Right wins five rounds; the 2-bit score saturates at 3.
        for (int rnd = 1; rnd <= 5; rnd++) begin
            repeat (5) begin
                set_in(0, 1, 0);
                tick();
                check_model("r_round");
                set_in(0, 0, 0);
                tick();
                check_model("r_round");
            end
            cmp($sformatf("score_r_round%0d", rnd), 32'(score_r), (rnd < 3) ? rnd : 3);
            cmp("winner_right", 32'(winner), 32'(2'b01));
            set_in(0, 0, 1);
            tick();
            check_model("r_restart");
            set_in(0, 0, 0);
            tick();
            check_model("r_restart");
        end

        // Move to position 2, then reset between edges with nonzero scores.
        repeat (2) begin
            set_in(0, 1, 0);
            tick();
            set_in(0, 0, 0);
            tick();
        end
        cmp("pos2_lights", 32'(lights), 32'h004);
        async_reset("midround_reset");
        tick();
        check_model("post_reset");

        // Randomized play against the model.
        for (int i = 0; i < 1500; i++) begin
            set_in(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 40) == 0);
            tick();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_field.md
# tug_field

Parametrised tug-of-war playfield: a row of `NUM_LIGHTS` LEDs with exactly one lit during play, moved one step left or right per button press. It replaces the per-LED light cells with one centralised block that also detects round wins, keeps per-player scores and restarts rounds. It sits between the synchronised button inputs and the LED and score display drivers.

## Interface
- `NUM_LIGHTS`, default 9: playfield length. Must be odd and at least 3. Index `NUM_LIGHTS-1` is the leftmost LED.
- `SCORE_W`, default 3: width of each player's score counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `L`  in  1  left-player button level, already synchronised to `clk`.
- `R`  in  1  right-player button level, already synchronised to `clk`.
- `restart`  in  1  level; starts a new round while high at a clock edge.
- `lights`  out  `NUM_LIGHTS`  LED drive; one-hot during play, all zero after a win.
- `winner`  out  2  `00` play in progress, `10` left won, `01` right won.
- `score_l`  out  `SCORE_W`  left-player round wins, saturating.
- `score_r`  out  `SCORE_W`  right-player round wins, saturating.

## Operation
- Centre index is `C = (NUM_LIGHTS-1)/2`. The position register `pos` has width `$clog2(NUM_LIGHTS)`.
- Press detection: a press is a rising edge of the input, detected as `X & ~X_prev` with a registered previous sample.
  - `L_prev` and `R_prev` reset to 1, so a button held through reset release produces no press until it is released and pressed again.
  - A held button yields exactly one press.
- State machine has three states:
  - PLAY: `lights = 1 << pos`, `winner = 00`.
  - WIN_L: `lights = 0`, `winner = 10`.
  - WIN_R: `lights = 0`, `winner = 01`.
- PLAY transitions, evaluated at each edge:
  - `restart` high: `pos <= C`. This has highest priority and any press that cycle is discarded.
  - L press and R press in the same cycle: no move, because the presses cancel.
  - L press only, `pos < NUM_LIGHTS-1`: `pos <= pos+1`.
  - L press only, `pos == NUM_LIGHTS-1`: go to WIN_L and increment `score_l` (saturating).
  - R press only, `pos > 0`: `pos <= pos-1`.
  - R press only, `pos == 0`: go to WIN_R and increment `score_r` (saturating).
- WIN_L and WIN_R:
  - Presses are ignored. Edge-detect registers still track the inputs.
  - `restart` high: go to PLAY with `pos <= C`. Scores are kept.
- Scores saturate at `2**SCORE_W-1`; further wins leave the value unchanged. Only `reset` clears the scores.
- Reset (asynchronous, any time including mid-round) forces:
  - state PLAY, `pos = C`, so `lights = 1 << C`;
  - `winner = 00`, `score_l = 0`, `score_r = 0`;
  - `L_prev = R_prev = 1`.

## Timing
- All outputs are decoded from registers only, with no combinational path from inputs to outputs.
- Latency is one cycle: a press first sampled at edge n updates `lights`, `winner` and score at edge n.
- The winning edge updates `lights` to 0, sets `winner` and increments the score in the same edge.
- `restart` takes effect at the first edge where it is sampled high. Holding it high keeps `pos` at `C` and holds off play.
- Presses can be accepted on back-to-back cycles only if the button toggles. The minimum press period per button is 2 cycles (high, low).
- Deasserting `reset` between edges gives normal operation from the next edge onward.

## Test plan
- Reset with `NUM_LIGHTS=9` -> `lights=9'b000010000`, `winner=00`, scores 0. Hold `L` high across reset release -> no movement until L falls and rises again.
- Four single-cycle L pulses spaced 2 cycles apart -> `lights` steps 0x010, 0x020, 0x040, 0x080, 0x100, changing one cycle after each rising edge. A fifth pulse -> `lights=0`, `winner=10`, `score_l=1`.
- In WIN_L, pulse R and L -> no change. Pulse `restart` -> `lights=0x010`, `winner=00`, `score_l` still 1.
- L and R rising in the same cycle -> `lights` unchanged. L held high for 10 cycles -> exactly one step.
- With `SCORE_W=2`, right player wins 5 rounds (5 R pulses per round, restart between) -> `score_r` reads 1, 2, 3, 3, 3.
- Assert `reset` asynchronously mid-round at `pos=2`, between edges -> `lights=0x010` immediately and scores 0. Assert `restart` together with an R press in PLAY -> `pos=C` and no move.
